// File: rtl/axi_lite_read_master.sv
// AXI4-Lite single-outstanding read initiator: request -> AR -> R -> one-cycle response pulse.
// Define AXI_READ_MASTER_TIMEOUT_EN to build the per-transaction timeout counter.
module axi_lite_read_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              o_resp_valid,
  output logic [DATA_W-1:0] o_resp_data,
  output logic [1:0]        o_resp_rresp,
  output logic              o_resp_err,
  output logic              o_resp_timeout,
  output logic              o_busy,
  output logic              o_arvalid,
  output logic [ADDR_W-1:0] o_araddr,
  input  logic              i_arready,
  input  logic              i_rvalid,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [1:0]        i_rresp,
  output logic              o_rready
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              timeout_q, timeout_d;
  logic              expire;

`ifdef AXI_READ_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // One budget spans ADDR and DATA; the counter parks at its limit.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && i_req_valid) begin
      cnt_d = '0;
    end else if ((state_q == ADDR || state_q == DATA) && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // A handshake in the limit cycle takes priority over expiry.
  assign expire = (cnt_q == CNT_MAX) &&
                  ((state_q == ADDR && !i_arready) || (state_q == DATA && !i_rvalid));

  always_ff @(posedge clk) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  assign expire = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      araddr_q  <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      timeout_q <= timeout_d;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          araddr_d = i_req_addr;
          state_d  = ADDR;
        end
      end
      ADDR: begin
        if (i_arready) begin
          state_d = DATA;
        end else if (expire) begin
          state_d   = RESP;
          rdata_d   = '0;
          rresp_d   = 2'b10;
          timeout_d = 1'b1;
        end
      end
      DATA: begin
        if (i_rvalid) begin
          state_d   = RESP;
          rdata_d   = i_rdata;
          rresp_d   = i_rresp;
          timeout_d = 1'b0;
        end else if (expire) begin
          state_d   = RESP;
          rdata_d   = '0;
          rresp_d   = 2'b10;
          timeout_d = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_req_ready  = (state_q == IDLE);
    o_busy       = (state_q != IDLE);
    o_arvalid    = (state_q == ADDR);
    o_rready     = (state_q == DATA);
    o_resp_valid = (state_q == RESP);
  end

  assign o_araddr     = araddr_q;
  assign o_resp_data  = rdata_q;
  assign o_resp_rresp = rresp_q;
  assign o_resp_err   = rresp_q[1] | timeout_q;

`ifdef AXI_READ_MASTER_TIMEOUT_EN
  assign o_resp_timeout = timeout_q;
`else
  assign o_resp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axi_lite_read_master.sv
// Scoreboard bench for axi_lite_read_master: randomized requests against a configurable AXI slave.
// Timeout scenarios run only when AXI_READ_MASTER_TIMEOUT_EN is defined.
module tb_axi_lite_read_master;

`ifdef AXI_READ_MASTER_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 256;
`endif

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [31:0] i_req_addr = '0;
  logic        o_resp_valid;
  logic [31:0] o_resp_data;
  logic [1:0]  o_resp_rresp;
  logic        o_resp_err;
  logic        o_resp_timeout;
  logic        o_busy;
  logic        o_arvalid;
  logic [31:0] o_araddr;
  logic        i_arready = 1'b0;
  logic        i_rvalid = 1'b0;
  logic [31:0] i_rdata = '0;
  logic [1:0]  i_rresp = '0;
  logic        o_rready;

  axi_lite_read_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_addr(i_req_addr),
    .o_resp_valid(o_resp_valid), .o_resp_data(o_resp_data), .o_resp_rresp(o_resp_rresp),
    .o_resp_err(o_resp_err), .o_resp_timeout(o_resp_timeout), .o_busy(o_busy),
    .o_arvalid(o_arvalid), .o_araddr(o_araddr), .i_arready(i_arready),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rresp(i_rresp), .o_rready(o_rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  rresp;
    logic        err;
    logic        to;
    int          exp_cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Slave memory contents as seen by the reference model.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[31:16]};
  endfunction
  function automatic logic [1:0] mem_resp(input logic [31:0] a);
    return a[9:8];
  endfunction

  // Slave behaviour knobs, set by the stimulus between transactions.
  bit          cfg_hang_ar = 0, cfg_hang_r = 0, cfg_force = 0;
  int          cfg_ar_delay = 0, cfg_r_delay = 0;
  logic [31:0] cfg_data = '0;
  logic [1:0]  cfg_resp = '0;
  int          ar_total = 0, r_total = 0;
  logic [31:0] slave_addr = '0;

  initial begin : slave
    int ar_wait = 0;
    int r_wait = 0;
    forever begin
      @(posedge clk); #1;
      if (o_arvalid) begin
        ar_wait++;
        ar_total++;
        i_arready = !cfg_hang_ar && (ar_wait > cfg_ar_delay);
        if (i_arready) slave_addr = o_araddr;
      end else begin
        ar_wait = 0;
        i_arready = 1'($urandom_range(0, 1));
      end
      if (o_rready) begin
        r_wait++;
        r_total++;
        i_rvalid = !cfg_hang_r && (r_wait > cfg_r_delay);
        i_rdata  = cfg_force ? cfg_data : mem_word(slave_addr);
        i_rresp  = cfg_force ? cfg_resp : mem_resp(slave_addr);
      end else begin
        r_wait = 0;
        i_rvalid = 1'($urandom_range(0, 1));
        i_rdata  = $urandom;
        i_rresp  = 2'($urandom);
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (i_reset) continue;
      if (o_arvalid) begin
        if (sb.size() == 0) check("araddr_no_txn", 64'(o_arvalid), 64'(0));
        else                check("araddr", 64'(o_araddr), 64'(sb[0].addr));
      end
      if (o_resp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp actual=data %0h required=no response", o_resp_data);
        end else begin
          e = sb.pop_front();
          check("resp_data", 64'(o_resp_data), 64'(e.data));
          check("resp_rresp", 64'(o_resp_rresp), 64'(e.rresp));
          check("resp_err", 64'(o_resp_err), 64'(e.err));
          check("resp_timeout", 64'(o_resp_timeout), 64'(e.to));
          if (e.exp_cyc >= 0) check("resp_cycle", 64'(cyc), 64'(e.exp_cyc));
        end
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "simulation time limit");
  end

  // lat = response cycle counted from the accept edge (3 for a zero-wait slave), -1 if not checked.
  task automatic issue(input logic [31:0] a, input bit keep, input bit expect_to,
                       input int lat, output int acc_cyc);
    exp_t e;
    int n = 0;
    i_req_valid = 1'b1;
    i_req_addr  = a;
    while (!o_req_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_wait", 64'(o_req_ready), 64'(1));
    e.addr = a;
    if (expect_to) begin
      e.data  = '0;
      e.rresp = 2'b10;
      e.err   = 1'b1;
      e.to    = 1'b1;
    end else begin
      e.data  = cfg_force ? cfg_data : mem_word(a);
      e.rresp = cfg_force ? cfg_resp : mem_resp(a);
      e.err   = e.rresp[1];
      e.to    = 1'b0;
    end
    e.exp_cyc = (lat < 0) ? -1 : cyc + lat;
    sb.push_back(e);
    @(posedge clk); #1;
    acc_cyc = cyc;
    if (!keep) begin
      i_req_valid = 1'b0;
      i_req_addr  = $urandom;
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((sb.size() != 0 || !o_req_ready) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 64'(sb.size()), 64'(0));
  endtask

  initial begin : stimulus
    int acc;
    int prev;
    int n;
    logic [31:0] a;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(o_req_ready), 64'(1));
    check("rst_busy", 64'(o_busy), 64'(0));
    check("rst_arvalid", 64'(o_arvalid), 64'(0));
    check("rst_rready", 64'(o_rready), 64'(0));
    check("rst_resp_valid", 64'(o_resp_valid), 64'(0));
    check("rst_araddr", 64'(o_araddr), 64'(0));
    check("rst_resp_data", 64'(o_resp_data), 64'(0));
    check("rst_resp_rresp", 64'(o_resp_rresp), 64'(0));
    check("rst_resp_err", 64'(o_resp_err), 64'(0));
    check("rst_resp_timeout", 64'(o_resp_timeout), 64'(0));
    i_reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Zero-wait read of 0x500 with a fixed data word.
    cfg_force = 1; cfg_data = 32'hDEAD_BEEF; cfg_resp = 2'b00;
    issue(32'h0000_0500, 0, 0, 3, acc);
    for (int k = 0; k < 3; k++) begin
      check("zw_req_ready_low", 64'(o_req_ready), 64'(0));
      @(posedge clk); #1;
    end
    check("zw_req_ready_back", 64'(o_req_ready), 64'(1));
    wait_done("zw_drain");

    // Slow slave: arready after 5 waits, rvalid after 3 more.
    cfg_force = 0; cfg_ar_delay = 5; cfg_r_delay = 3;
    ar_total = 0; r_total = 0;
    issue(32'h0000_1A40, 0, 0, -1, acc);
    wait_done("slow_drain");
    check("slow_ar_cycles", 64'(ar_total), 64'(6));
    check("slow_r_cycles", 64'(r_total), 64'(4));
    cfg_ar_delay = 0; cfg_r_delay = 0;

    // DECERR response still carries data.
    cfg_force = 1; cfg_data = 32'h0000_1234; cfg_resp = 2'b11;
    issue(32'h0000_2000, 0, 0, 3, acc);
    wait_done("decerr_drain");
    cfg_force = 0;

    // Reset while waiting for the R beat abandons the transaction.
    cfg_r_delay = 30;
    issue(32'h0000_3300, 0, 0, -1, acc);
    n = 0;
    while (!o_rready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_mid_reached_data", 64'(o_rready), 64'(1));
    i_reset = 1'b1;
    void'(sb.pop_back());
    @(posedge clk); #1;
    i_reset = 1'b0;
    check("rst_mid_rready", 64'(o_rready), 64'(0));
    check("rst_mid_busy", 64'(o_busy), 64'(0));
    check("rst_mid_req_ready", 64'(o_req_ready), 64'(1));
    check("rst_mid_araddr", 64'(o_araddr), 64'(0));
    check("rst_mid_resp_data", 64'(o_resp_data), 64'(0));
    repeat (10) @(posedge clk);
    #1;
    check("rst_mid_idle", 64'(o_busy), 64'(0));
    cfg_r_delay = 0;

`ifdef AXI_READ_MASTER_TIMEOUT_EN
    // Slave never accepts the address.
    cfg_hang_ar = 1; ar_total = 0; r_total = 0;
    issue(32'h0000_4440, 0, 1, 9, acc);
    wait_done("to_ar_drain");
    check("to_ar_cycles", 64'(ar_total), 64'(8));
    check("to_ar_r_cycles", 64'(r_total), 64'(0));
    cfg_hang_ar = 0;

    // arready in the limit cycle wins; rvalid in the single DATA cycle completes.
    cfg_ar_delay = 7; ar_total = 0; r_total = 0;
    issue(32'h0000_5550, 0, 0, 10, acc);
    wait_done("to_edge_drain");
    check("to_edge_ar_cycles", 64'(ar_total), 64'(8));
    check("to_edge_r_cycles", 64'(r_total), 64'(1));

    // Same, but the R beat never comes: DATA gets one cycle.
    cfg_hang_r = 1; ar_total = 0; r_total = 0;
    issue(32'h0000_6660, 0, 1, 10, acc);
    wait_done("to_r_drain");
    check("to_r_r_cycles", 64'(r_total), 64'(1));
    cfg_hang_r = 0; cfg_ar_delay = 0;
`endif

    // Request held continuously: one accept every 4 cycles.
    prev = -1;
    for (int k = 0; k < 6; k++) begin
      a = 32'h0001_0000 + 32'(k * 4);
      issue(a, (k != 5), 0, 3, acc);
      if (prev >= 0) check("b2b_spacing", 64'(acc - prev), 64'(4));
      prev = acc;
    end
    wait_done("b2b_drain");

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      cfg_ar_delay = $urandom_range(0, 3);
      cfg_r_delay  = $urandom_range(0, 3);
      a = $urandom & 32'hFFFF_FFFC;
      issue(a, 0, 0, (cfg_ar_delay == 0 && cfg_r_delay == 0) ? 3 : -1, acc);
      wait_done("rand_drain");
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_read_master.md
# axi_lite_read_master

AXI4-Lite read initiator for the CL abstraction layer. It accepts single-word read requests from internal CL logic and drives the AR channel. It then accepts the R beat and returns data plus status to the requester as a one-cycle response pulse. It is the master-side counterpart of the read-response path and is used to read registers in peer CL blocks and the shell. It supports one outstanding transaction.

## Interface
- ADDR_W, 32, AR address width
- DATA_W, 32, R data width
- TIMEOUT_CYCLES, 256, cycle budget per transaction when the timeout feature is compiled in; must be ≥ 2

Ports:
- clk  in  1  clock; all logic on its rising edge
- i_reset  in  1  synchronous, active-high reset
- i_req_valid  in  1  request strobe from internal logic
- o_req_ready  out  1  high only in IDLE; a request is accepted when i_req_valid && o_req_ready
- i_req_addr  in  ADDR_W  read address, sampled on accept
- o_resp_valid  out  1  one-cycle response pulse
- o_resp_data  out  DATA_W  captured RDATA; 0 on timeout
- o_resp_rresp  out  2  captured RRESP; 2'b10 on timeout
- o_resp_err  out  1  RRESP[1] set, or timeout
- o_resp_timeout  out  1  transaction ended by timeout
- o_busy  out  1  state ≠ IDLE
- o_arvalid  out  1  AR valid
- o_araddr  out  ADDR_W  AR address, held stable while o_arvalid is high
- i_arready  in  1  AR ready
- i_rvalid  in  1  R valid
- i_rdata  in  DATA_W  R data
- i_rresp  in  2  R response
- o_rready  out  1  R ready

## Operation
- FSM states: IDLE, ADDR, DATA, RESP. All outputs are Moore outputs decoded from registered state and registers. There is no combinational path from any input to any output.
- IDLE: o_req_ready = 1. On accept, latch i_req_addr into o_araddr, clear the timeout counter, and go to ADDR.
- ADDR: o_arvalid = 1, o_rready = 0. On i_arready, go to DATA. o_araddr does not change until the next accept.
- DATA: o_rready = 1. On i_rvalid, capture i_rdata and i_rresp and go to RESP. i_rvalid is ignored in every other state; o_rready is low in those states.
- RESP: o_resp_valid = 1 for exactly one cycle, then go to IDLE. o_resp_err = i_rresp captured[1], so SLVERR and DECERR both flag an error. Response registers hold their values until the next RESP.
- Reset, including mid-transaction: next edge state = IDLE. All outputs are 0 except o_req_ready = 1. o_araddr, o_resp_data and o_resp_rresp are 0. Any in-flight AXI transaction is abandoned.
- A request asserted in ADDR, DATA or RESP is not accepted; the requester holds it.

## Timing
- Accept at edge N: o_arvalid is high in cycle N+1.
- Zero-wait slave (arready in N+1, rvalid in N+2): o_resp_valid in N+3, o_req_ready in N+4.
- Minimum request-to-request spacing is 4 cycles.
- AR and R handshakes complete on the edge where valid && ready.

## Configuration
- Macro: AXI_READ_MASTER_TIMEOUT_EN.
- Defined:
  - The counter clears on accept, increments every cycle in ADDR and DATA (a single budget across both), and saturates at TIMEOUT_CYCLES-1.
  - In an ADDR or DATA cycle with counter == TIMEOUT_CYCLES-1 and no completing handshake in that cycle, go to RESP with o_resp_timeout = 1, o_resp_err = 1, o_resp_data = 0, o_resp_rresp = 2'b10.
  - A handshake in the limit cycle wins over the timeout. After an AR handshake at the limit, DATA has exactly one cycle to see i_rvalid.
  - Dropping o_arvalid on timeout is deliberate recovery from a hung slave. Any late R beat is stalled, because o_rready is 0 outside DATA.
- Undefined: no counter is built. The block waits indefinitely in ADDR and DATA, and o_resp_timeout is tied to 0.

## Test plan
- Zero-wait slave, accept addr 0x0000_0500 with RDATA 0xDEAD_BEEF, RRESP 0 -> o_araddr = 0x500, o_resp_valid pulses at N+3 with data 0xDEAD_BEEF, err 0; o_req_ready is low N+1..N+3.
- arready delayed 5 cycles, rvalid delayed 3 more -> o_arvalid high for 6 cycles with o_araddr stable; o_rready high for 4 cycles; exactly one response pulse.
- RRESP = 2'b11 with RDATA 0x1234 -> o_resp_err = 1, o_resp_rresp = 3, o_resp_data = 0x1234, o_resp_timeout = 0.
- i_reset asserted in DATA -> next cycle o_rready = 0, o_busy = 0, o_req_ready = 1. A stray i_rvalid afterwards produces no response.
- With AXI_READ_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES = 8, slave never raises arready -> o_arvalid high for 8 cycles, then o_resp_valid with timeout = 1, err = 1, data = 0. Repeat with arready in the 8th cycle -> goes to DATA; rvalid in the next cycle completes normally.
- i_req_valid held continuously with a zero-wait slave -> accepts every 4 cycles, with one response per accept and matching addresses.
